// File: rtl/upsample2d_stream_ctrl.sv
// Nearest-neighbour upsampler. Reads one input row into a line buffer, then streams it
// out SCALE times with every pixel repeated SCALE times, in flattened (c,oh,ow) order.
module upsample2d_stream_ctrl #(
    parameter int CH        = 1,
    parameter int IN_H      = 1,
    parameter int IN_W      = 1,
    parameter int SCALE     = 2,
    parameter int WIDTH     = 16,
    parameter     precision = "Q8.8",
    localparam int OUT_H    = IN_H * SCALE,
    localparam int OUT_W    = IN_W * SCALE,
    localparam int RD_AW    = (CH * IN_H * IN_W > 1) ? $clog2(CH * IN_H * IN_W) : 1,
    localparam int WR_AW    = (CH * OUT_H * OUT_W > 1) ? $clog2(CH * OUT_H * OUT_W) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [RD_AW-1:0]        rd_addr,
    input  logic signed [WIDTH-1:0] rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic [WR_AW-1:0]        out_addr,
    output logic                    out_last
);

    localparam int IW_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int SC_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [IW_W-1:0]  IW_LAST   = IW_W'(IN_W - 1);
    localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(SCALE - 1);
    localparam logic [WR_AW-1:0] LAST_ADDR = WR_AW'(CH * OUT_H * OUT_W - 1);

    typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

    state_t                    state;
    logic signed [WIDTH-1:0]   lb [IN_W];
    logic [IW_W-1:0]           iw;
    logic                      cap_pending;
    logic [IW_W-1:0]           cap_idx;
    logic [IW_W-1:0]           px;
    logic [IW_W-1:0]           px_next;
    logic [SC_W-1:0]           sc;
    logic [SC_W-1:0]           rep;

    assign px_next = (px == IW_LAST) ? '0 : px + IW_W'(1);

    // Line buffer capture: read data lands one cycle after its strobe.
    always_ff @(posedge clk) begin
        if (cap_pending)
            lb[cap_idx] <= rd_data;
    end

    // Both address streams are plain running counters, since rows are visited in
    // exactly the flattened order of the input and output tensors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            out_last    <= 1'b0;
            iw          <= '0;
            cap_pending <= 1'b0;
            cap_idx     <= '0;
            px          <= '0;
            sc          <= '0;
            rep         <= '0;
        end else begin
            done        <= 1'b0;
            cap_pending <= rd_en;
            cap_idx     <= iw;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FILL;
                        busy     <= 1'b1;
                        rd_en    <= 1'b1;
                        rd_addr  <= '0;
                        iw       <= '0;
                        out_addr <= '0;
                        out_last <= 1'b0;
                    end
                end
                FILL: begin
                    if (rd_en) begin
                        rd_addr <= rd_addr + RD_AW'(1);
                        if (iw == IW_LAST)
                            rd_en <= 1'b0;
                        else
                            iw <= iw + IW_W'(1);
                    end
                    // With a one-pixel row the only entry is still in flight, so bypass it.
                    if (cap_pending && cap_idx == IW_LAST) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_data  <= (IN_W == 1) ? rd_data : lb[0];
                        out_last  <= (out_addr == LAST_ADDR);
                        px        <= '0;
                        sc        <= '0;
                        rep       <= '0;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_addr <= out_addr + WR_AW'(1);
                            out_last <= ((out_addr + WR_AW'(1)) == LAST_ADDR);
                            if (sc == SC_LAST) begin
                                sc       <= '0;
                                px       <= px_next;
                                out_data <= lb[px_next];
                                if (px == IW_LAST) begin
                                    if (rep == SC_LAST) begin
                                        rep       <= '0;
                                        state     <= FILL;
                                        out_valid <= 1'b0;
                                        rd_en     <= 1'b1;
                                        iw        <= '0;
                                    end else begin
                                        rep <= rep + SC_W'(1);
                                    end
                                end
                            end else begin
                                sc <= sc + SC_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upsample2d_stream_ctrl.sv
// Directed bench for upsample2d_stream_ctrl: three configurations, each fed from a small
// behavioural memory, with output streams compared against hand-computed sequences.
module tb_upsample2d_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    logic rst;

    // Configuration A: CH=1, IN_H=2, IN_W=2, SCALE=2
    logic                start_a, busy_a, done_a, rd_en_a, out_valid_a, out_ready_a, out_last_a;
    logic [1:0]          rd_addr_a;
    logic [3:0]          out_addr_a;
    logic signed [15:0]  rd_data_a, out_data_a;
    logic signed [15:0]  mem_a [4];
    logic signed [15:0]  exp_a [16];

    // Configuration B: CH=2, IN_H=1, IN_W=3, SCALE=3
    logic                start_b, busy_b, done_b, rd_en_b, out_valid_b, out_ready_b, out_last_b;
    logic [2:0]          rd_addr_b;
    logic [5:0]          out_addr_b;
    logic signed [15:0]  rd_data_b, out_data_b;
    logic signed [15:0]  mem_b [8];

    // Configuration C: CH=1, IN_H=1, IN_W=4, SCALE=1
    logic                start_c, busy_c, done_c, rd_en_c, out_valid_c, out_ready_c, out_last_c;
    logic [1:0]          rd_addr_c;
    logic [1:0]          out_addr_c;
    logic signed [15:0]  rd_data_c, out_data_c;
    logic signed [15:0]  mem_c [4];

    upsample2d_stream_ctrl #(.CH(1), .IN_H(2), .IN_W(2), .SCALE(2), .WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_addr(out_addr_a), .out_last(out_last_a)
    );

    upsample2d_stream_ctrl #(.CH(2), .IN_H(1), .IN_W(3), .SCALE(3), .WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_addr(out_addr_b), .out_last(out_last_b)
    );

    upsample2d_stream_ctrl #(.CH(1), .IN_H(1), .IN_W(4), .SCALE(1), .WIDTH(16)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
        .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
        .out_addr(out_addr_c), .out_last(out_last_c)
    );

    // Memories answer one cycle after a strobe and return junk otherwise.
    always @(posedge clk) begin
        rd_data_a <= rd_en_a ? mem_a[rd_addr_a] : 16'($urandom);
        rd_data_b <= rd_en_b ? mem_b[rd_addr_b] : 16'($urandom);
        rd_data_c <= rd_en_c ? mem_c[rd_addr_c] : 16'($urandom);
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Upsample2d reference for configuration B: value in[c][oh/S][ow/S].
    function automatic logic signed [15:0] refB(input int i);
        int c, r, oh, ow;
        c  = i / 27;
        r  = i % 27;
        oh = r / 9;
        ow = r % 9;
        return mem_b[(c + oh / 3) * 3 + ow / 3];
    endfunction

    // One tensor on configuration A. abortAfter >= 0 asserts rst once that many
    // transfers have completed; pokeStart raises start again in the middle of EMIT.
    task automatic applyStimulus(input bit randomReady, input int abortAfter, input bit pokeStart);
        int n = 0, t0, firstValid = -1;
        bit fin = 0, poked = 0, prevStall = 0, rdy;
        logic signed [15:0] pd;
        logic [3:0] pa;
        @(negedge clk);
        start_a = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_a = 1'b0;
        checkOutput("a_first_rd_en", rd_en_a, 1);
        checkOutput("a_busy_fill", busy_a, 1);
        for (int k = 0; k < 400 && !fin; k++) begin
            start_a = 1'b0;
            if (abortAfter >= 0 && n == abortAfter) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkOutput("a_abort_valid", out_valid_a, 0);
                checkOutput("a_abort_busy", busy_a, 0);
                checkOutput("a_abort_done", done_a, 0);
                repeat (3) @(negedge clk);
                checkOutput("a_abort_no_done", done_a, 0);
                checkOutput("a_abort_count", n, 5);
                return;
            end
            if (prevStall) begin
                checkOutput("a_stall_valid", out_valid_a, 1);
                checkOutput("a_stall_data", out_data_a, pd);
                checkOutput("a_stall_addr", out_addr_a, pa);
            end
            if (out_valid_a && firstValid < 0) firstValid = cyc - t0;
            if (done_a) begin
                if (!randomReady) checkOutput("a_done_latency", cyc - t0, 23);
                fin = 1;
            end else begin
                rdy = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
                out_ready_a = rdy;
                if (out_valid_a && rdy) begin
                    if (n < 16) checkOutput("a_data", out_data_a, exp_a[n]);
                    checkOutput("a_addr", out_addr_a, n);
                    checkOutput("a_last", out_last_a, (n == 15));
                    n++;
                end
                prevStall = out_valid_a && !rdy;
                pd = out_data_a;
                pa = out_addr_a;
                if (pokeStart && !poked && n == 6) begin
                    start_a = 1'b1;
                    poked = 1;
                end
                @(negedge clk);
            end
        end
        if (!fin) checkOutput("a_timeout", 0, 1);
        if (!randomReady) checkOutput("a_first_valid", firstValid, 4);
        checkOutput("a_count", n, 16);
        @(negedge clk);
        checkOutput("a_done_pulse", done_a, 0);
        checkOutput("a_idle_busy", busy_a, 0);
        checkOutput("a_idle_valid", out_valid_a, 0);
    endtask

    task automatic applyStimulusWide();
        int n = 0, rds = 0, t0;
        bit fin = 0;
        out_ready_b = 1'b1;
        @(negedge clk);
        start_b = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 300 && !fin; k++) begin
            if (rd_en_b) begin
                checkOutput("b_rd_addr", rd_addr_b, rds);
                checkOutput("b_rd_no_valid", out_valid_b, 0);
                rds++;
            end
            if (out_valid_b) begin
                checkOutput("b_data", out_data_b, refB(n));
                checkOutput("b_addr", out_addr_b, n);
                checkOutput("b_last", out_last_b, (n == 53));
                n++;
            end
            if (done_b) begin
                checkOutput("b_done_latency", cyc - t0, 63);
                fin = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!fin) checkOutput("b_timeout", 0, 1);
        checkOutput("b_count", n, 54);
        checkOutput("b_reads", rds, 6);
    endtask

    task automatic applyStimulusCopy();
        int n = 0, t0;
        bit fin = 0;
        out_ready_c = 1'b1;
        @(negedge clk);
        start_c = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_c = 1'b0;
        for (int k = 0; k < 100 && !fin; k++) begin
            if (out_valid_c) begin
                if (n < 4) checkOutput("c_data", out_data_c, mem_c[n]);
                checkOutput("c_addr", out_addr_c, n);
                checkOutput("c_last", out_last_c, (n == 3));
                n++;
            end
            if (done_c) begin
                checkOutput("c_done_latency", cyc - t0, 10);
                fin = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!fin) checkOutput("c_timeout", 0, 1);
        checkOutput("c_count", n, 4);
    endtask

    initial begin
        mem_a = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        exp_a = '{16'sd1, 16'sd1, 16'sd2, 16'sd2, 16'sd1, 16'sd1, 16'sd2, 16'sd2,
                  16'sd3, 16'sd3, 16'sd4, 16'sd4, 16'sd3, 16'sd3, 16'sd4, 16'sd4};
        mem_b = '{-16'sd32768, 16'sd5, -16'sd7, 16'sd32767, 16'sd0, 16'sd100, 16'sd0, 16'sd0};
        mem_c = '{16'sd10, -16'sd20, 16'sd30, -16'sd40};
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        out_ready_a = 1'b0; out_ready_b = 1'b0; out_ready_c = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_done", done_a, 0);
        checkOutput("rst_rd_en", rd_en_a, 0);
        checkOutput("rst_rd_addr", rd_addr_a, 0);
        checkOutput("rst_valid", out_valid_a, 0);
        checkOutput("rst_data", out_data_a, 0);
        checkOutput("rst_addr", out_addr_a, 0);
        checkOutput("rst_last", out_last_a, 0);
        rst = 1'b0;

        // start together with rst must be dropped
        @(negedge clk);
        rst = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        checkOutput("rst_start_busy", busy_a, 0);
        checkOutput("rst_start_rd_en", rd_en_a, 0);

        applyStimulus(1'b0, -1, 1'b0);
        applyStimulus(1'b1, -1, 1'b0);
        applyStimulus(1'b0, -1, 1'b1);
        applyStimulus(1'b0, 5, 1'b0);
        applyStimulus(1'b0, -1, 1'b0);
        applyStimulusWide();
        applyStimulusCopy();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
